serial_word_cmp: RTL and testbench



---
 rtl/serial_word_cmp_if.sv | 39 +++
 rtl/serial_word_cmp.sv | 110 +++++++++++
 tb/tb_serial_word_cmp.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_word_cmp_if.sv
// Operand/result bundle for the serial word comparator.
// The requester drives start/a/b; the comparator drives status and flags.
interface serial_word_cmp_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;
  logic             lt;

  modport master (
    output start,
    output a,
    output b,
    input  ready,
    input  busy,
    input  done,
    input  eq,
    input  gt,
    input  lt
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output ready,
    output busy,
    output done,
    output eq,
    output gt,
    output lt
  );
endinterface

// File: rtl/serial_word_cmp.sv
// Multi-cycle comparator: walks two operands 2 bits per cycle, MSB first,
// stopping at the first differing slice; reports eq/gt/lt with a done pulse.
module serial_word_cmp #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic clk,
  input  logic reset,
  serial_word_cmp_if.slave cmp
);
  localparam int S  = WIDTH / 2;
  localparam int CW = (S > 1) ? $clog2(S) : 1;
  localparam logic [CW-1:0] CLAST = CW'(S - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    c_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             eq_q;
  logic             gt_q;
  logic             lt_q;

  logic [1:0] sa;
  logic [1:0] sb;
  logic       slc_eq;
  logic       slc_gt;

  // Flipping the sign bit of the top slice maps two's complement
  // ordering onto unsigned ordering for that slice.
  always_comb begin
    sa = a_q[WIDTH-1 -: 2];
    sb = b_q[WIDTH-1 -: 2];
    if (SIGNED && (c_q == '0)) begin
      sa[1] = ~sa[1];
      sb[1] = ~sb[1];
    end
    slc_eq = &(sa ~^ sb);
    slc_gt = (sa > sb);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cmp.start) begin
            a_q     <= cmp.a;
            b_q     <= cmp.b;
            c_q     <= '0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (!slc_eq) begin
            gt_q    <= slc_gt;
            lt_q    <= ~slc_gt;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (c_q == CLAST) begin
            eq_q    <= 1'b1;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            a_q <= a_q << 2;
            b_q <= b_q << 2;
            c_q <= c_q + CW'(1);
          end
        end
        DONE: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmp.ready = ready_q;
  assign cmp.busy  = busy_q;
  assign cmp.done  = done_q;
  assign cmp.eq    = eq_q;
  assign cmp.gt    = gt_q;
  assign cmp.lt    = lt_q;
endmodule

// File: tb/tb_serial_word_cmp.sv
// Bench for serial_word_cmp: unsigned and signed instances side by side,
// checked every cycle against a transaction-level model plus literals.
module tb_serial_word_cmp;
  localparam int W = 8;
  localparam int S = W / 2;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   chk_on = 1'b0;

  always #5 clk = ~clk;

  serial_word_cmp_if #(.WIDTH(W)) if_u ();
  serial_word_cmp_if #(.WIDTH(W)) if_s ();

  assign if_s.start = if_u.start;
  assign if_s.a     = if_u.a;
  assign if_s.b     = if_u.b;

  serial_word_cmp #(.WIDTH(W), .SIGNED(1'b0)) u_dut_u (
    .clk   (clk),
    .reset (reset),
    .cmp   (if_u)
  );

  serial_word_cmp #(.WIDTH(W), .SIGNED(1'b1)) u_dut_s (
    .clk   (clk),
    .reset (reset),
    .cmp   (if_s)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Cycles until done: index of first differing slice + 1, else S.
  function automatic int first_k(logic [W-1:0] a, logic [W-1:0] b);
    for (int i = 0; i < S; i++) begin
      if (a[W-1-2*i -: 2] != b[W-1-2*i -: 2]) return i + 1;
    end
    return S;
  endfunction

  // Flags as {eq, gt, lt} from whole-word arithmetic.
  function automatic logic [2:0] ref_res(logic [W-1:0] a,
                                         logic [W-1:0] b, bit sgn);
    bit g;
    if (a == b) return 3'b100;
    g = sgn ? ($signed(a) > $signed(b)) : (a > b);
    return g ? 3'b010 : 3'b001;
  endfunction

  // Model: per DUT, cycles since accept, latency and result.
  bit         m_busy [2] = '{0, 0};
  int         m_age  [2] = '{0, 0};
  int         m_k    [2] = '{0, 0};
  logic [2:0] m_res  [2] = '{3'b0, 3'b0};
  logic [2:0] m_held [2] = '{3'b0, 3'b0};

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_busy[d] = 1'b0;
        m_held[d] = 3'b000;
      end else if (!m_busy[d]) begin
        if (if_u.start) begin
          m_busy[d] = 1'b1;
          m_age[d]  = 1;
          m_k[d]    = first_k(if_u.a, if_u.b);
          m_res[d]  = ref_res(if_u.a, if_u.b, d == 1);
          m_held[d] = 3'b000;
        end
      end else if (m_age[d] == m_k[d] + 1) begin
        m_busy[d] = 1'b0;
        m_held[d] = m_res[d];
      end else begin
        m_age[d]++;
      end
    end
  end

  task automatic cmp_dut(string nm, int d, logic r, logic bz,
                         logic dn, logic e, logic g, logic l);
    bit fin;
    logic [2:0] ef;
    fin = m_busy[d] && (m_age[d] == m_k[d] + 1);
    ef  = !m_busy[d] ? m_held[d] : (fin ? m_res[d] : 3'b000);
    chk({nm, ".ready"}, r, !m_busy[d]);
    chk({nm, ".busy"}, bz, m_busy[d]);
    chk({nm, ".done"}, dn, fin);
    chk({nm, ".flags"}, {e, g, l}, ef);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp_dut("u", 0, if_u.ready, if_u.busy, if_u.done,
              if_u.eq, if_u.gt, if_u.lt);
      cmp_dut("s", 1, if_s.ready, if_s.busy, if_s.done,
              if_s.eq, if_s.gt, if_s.lt);
    end
  end

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (!if_u.done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic [2:0] fu,
                        output logic [2:0] fs);
    @(negedge clk);
    if_u.a     = a;
    if_u.b     = b;
    if_u.start = 1'b1;
    @(negedge clk);
    if_u.start = 1'b0;
    wait_done(0, lat);
    fu = {if_u.eq, if_u.gt, if_u.lt};
    fs = {if_s.eq, if_s.gt, if_s.lt};
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int last;
    int rc;
    int cyc;
    int mode;
    logic [2:0] fu;
    logic [2:0] fs;
    logic [W-1:0] ra;

    reset      = 1'b1;
    if_u.start = 1'b1;
    if_u.a     = 8'h11;
    if_u.b     = 8'h22;
    @(negedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst.ready", if_u.ready, 1'b1);
    chk("rst.busy", if_u.busy, 1'b0);
    chk("rst.done", if_u.done, 1'b0);
    chk("rst.flags", {if_u.eq, if_u.gt, if_u.lt}, 3'b000);
    reset      = 1'b0;
    if_u.start = 1'b0;

    run_op(8'hA5, 8'hA5, lat, fu, fs);
    chk("eq.lat", lat, 4);
    chk("eq.u", fu, 3'b100);
    chk("eq.s", fs, 3'b100);
    repeat (3) @(negedge clk);
    chk("eq.hold", {if_u.eq, if_u.gt, if_u.lt}, 3'b100);

    run_op(8'h80, 8'h7F, lat, fu, fs);
    chk("early.lat", lat, 1);
    chk("early.u", fu, 3'b010);
    chk("early.s", fs, 3'b001);

    run_op(8'h34, 8'h36, lat, fu, fs);
    chk("late.lat", lat, 4);
    chk("late.u", fu, 3'b001);
    chk("late.s", fs, 3'b001);
    run_op(8'h36, 8'h34, lat, fu, fs);
    chk("late.sw.u", fu, 3'b010);
    chk("late.sw.s", fs, 3'b010);

    @(negedge clk);
    if_u.a     = 8'h00;
    if_u.b     = 8'h00;
    if_u.start = 1'b1;
    @(negedge clk);
    if_u.start = 1'b0;
    @(negedge clk);
    if_u.a     = 8'hFF;
    if_u.start = 1'b1;
    @(negedge clk);
    if_u.start = 1'b0;
    wait_done(2, lat);
    chk("busy.lat", lat, 4);
    chk("busy.u", {if_u.eq, if_u.gt, if_u.lt}, 3'b100);
    chk("busy.s", {if_s.eq, if_s.gt, if_s.lt}, 3'b100);

    @(negedge clk);
    if_u.a     = 8'h00;
    if_u.start = 1'b1;
    @(negedge clk);
    if_u.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort.ready", if_u.ready, 1'b1);
    chk("abort.busy", if_s.busy, 1'b0);
    chk("abort.flags", {if_u.eq, if_u.gt, if_u.lt}, 3'b000);
    rc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (if_u.done || if_s.done) rc++;
    end
    chk("abort.nodone", rc, 0);

    if_u.a     = 8'h12;
    if_u.b     = 8'h13;
    if_u.start = 1'b1;
    last = -1;
    rc   = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (if_u.done) begin
        chk("b2b.u", {if_u.eq, if_u.gt, if_u.lt}, 3'b001);
        chk("b2b.s", {if_s.eq, if_s.gt, if_s.lt}, 3'b001);
        if (last >= 0) begin
          chk("b2b.gap", i - last, 6);
          chk("b2b.ready", rc, 1);
        end
        last = i;
        rc   = 0;
      end else if (if_u.ready) begin
        rc++;
      end
    end
    chk("b2b.seen", last >= 0, 1'b1);
    if_u.start = 1'b0;
    repeat (8) @(negedge clk);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      mode = $urandom_range(0, 3);
      ra   = W'($urandom);
      if_u.a = ra;
      case (mode)
        0: if_u.b = ra;
        1: if_u.b = ra ^ W'(1 << $urandom_range(0, W - 1));
        default: if_u.b = W'($urandom);
      endcase
      if_u.start = ($urandom_range(0, 2) != 0);
      reset      = ($urandom_range(0, 80) == 0);
    end
    reset      = 1'b0;
    if_u.start = 1'b0;
    cyc = 0;
    repeat (8) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
